// File: rtl/tmcu_gpio_ctrl_if.sv
// tmcu_gpio_ctrl_if: single-outstanding request/response bus between a master and the GPIO block
interface tmcu_gpio_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   modport master (output req_valid, req_write, req_addr, req_wdata, resp_ready,
                   input  req_ready, resp_valid, resp_rdata, resp_err);
   modport slave  (input  req_valid, req_write, req_addr, req_wdata, resp_ready,
                   output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/tmcu_gpio_ctrl.sv
// tmcu_gpio_ctrl: 32-pin GPIO with register bus, synchronized inputs and edge interrupts
// Define TMCU_GPIO_DEBOUNCE_EN to add per-pin debounce counters ahead of DATA_IN.
module tmcu_gpio_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   tmcu_gpio_ctrl_if.slave   bus,
   output logic [31:0]       o_gpio_write,
   output logic [31:0]       o_gpio_dir,
   input  logic [31:0]       i_gpio_read,
   output logic              o_irq
);
   typedef enum logic {IDLE, RESP} state_t;
   state_t      r_state;
   logic [31:0] r_data_out, r_dir, r_irq_en, r_irq_type, r_irq_status;
   logic [31:0] r_sync1, r_sync2, r_data_in, r_data_in_d, r_resp_rdata;
   logic        r_irq;
   logic        w_acc, w_we, w_unused;
   logic [2:0]  w_sel;
   logic [31:0] w_wd, w_set, w_clr, w_status_next, w_en_next, w_rdata;
   always_comb begin
      w_acc         = bus.req_valid && r_state == IDLE;
      w_we          = w_acc && bus.req_write;
      w_sel         = bus.req_addr[4:2];
      w_wd          = bus.req_wdata;
      w_set         = (r_data_in & ~r_data_in_d & r_irq_type) | (~r_data_in & r_data_in_d & ~r_irq_type);
      w_clr         = (w_we && w_sel == 3'd5) ? w_wd : '0;
      // a new edge outranks a simultaneous clear
      w_status_next = (r_irq_status & ~w_clr) | w_set;
      w_en_next     = (w_we && w_sel == 3'd3) ? w_wd : r_irq_en;
      w_rdata       = bus.req_write  ? '0 :
                      w_sel == 3'd1  ? r_dir :
                      w_sel == 3'd2  ? r_data_in :
                      w_sel == 3'd3  ? r_irq_en :
                      w_sel == 3'd4  ? r_irq_type :
                      w_sel == 3'd5  ? r_irq_status : r_data_out;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_data_out   <= '0;
         r_dir        <= '1;
         r_irq_en     <= '0;
         r_irq_type   <= '1;
         r_irq_status <= '0;
         r_irq        <= 1'b0;
         r_resp_rdata <= '0;
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_data_in_d  <= '0;
      end else begin
         r_state      <= w_acc ? RESP : (r_state == RESP && bus.resp_ready) ? IDLE : r_state;
         r_resp_rdata <= w_acc ? w_rdata : r_resp_rdata;
         r_data_out   <= !w_we        ? r_data_out :
                         w_sel == 3'd0 ? w_wd :
                         w_sel == 3'd6 ? r_data_out | w_wd :
                         w_sel == 3'd7 ? r_data_out & ~w_wd : r_data_out;
         r_dir        <= (w_we && w_sel == 3'd1) ? w_wd : r_dir;
         r_irq_type   <= (w_we && w_sel == 3'd4) ? w_wd : r_irq_type;
         r_irq_en     <= w_en_next;
         r_irq_status <= w_status_next;
         r_irq        <= |(w_status_next & w_en_next);
         r_sync1      <= i_gpio_read;
         r_sync2      <= r_sync1;
         r_data_in_d  <= r_data_in;
      end
   end
`ifdef TMCU_GPIO_DEBOUNCE_EN
   logic [7:0] r_cnt [32];
   // counter tracks consecutive cycles the synchronized pin differs from DATA_IN
   always_ff @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (rst) begin
            r_cnt[i]     <= '0;
            r_data_in[i] <= 1'b0;
         end else if (r_sync2[i] == r_data_in[i]) begin
            r_cnt[i]     <= '0;
         end else if (r_cnt[i] == 8'(DEBOUNCE_CYCLES)) begin
            r_cnt[i]     <= '0;
            r_data_in[i] <= r_sync2[i];
         end else begin
            r_cnt[i]     <= r_cnt[i] + 8'd1;
         end
      end
   end
`else
   always_ff @(posedge clk) r_data_in <= rst ? '0 : r_sync2;
`endif
   assign w_unused       = ^{bus.req_addr[1:0], DEBOUNCE_CYCLES[0]};
   assign bus.req_ready  = r_state == IDLE;
   assign bus.resp_valid = r_state == RESP;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.resp_err   = 1'b0;
   assign o_gpio_write   = r_data_out;
   assign o_gpio_dir     = r_dir;
   assign o_irq          = r_irq;
endmodule
